// File: rtl/mult_hilo_ctrl.sv
// Multi-cycle multiply controller that commits a 64-bit product into HI/LO.
// It also accepts direct MTHI/MTLO writes, which abort any multiply in flight.

module MULT32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  logic signed [63:0] aExt;
  logic signed [63:0] bExt;

  assign aExt = {{32{a[31]}}, a};
  assign bExt = {{32{b[31]}}, b};
  assign p    = aExt * bExt;
endmodule

module MULT32_U (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  logic [63:0] aExt;
  logic [63:0] bExt;

  assign aExt = {32'd0, a};
  assign bExt = {32'd0, b};
  assign p    = aExt * bExt;
endmodule

module mult_hilo_ctrl #(
  parameter int LATENCY = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MTHI,
  input  logic        MTLO,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [2:0] CntLoad = 3'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        signed_q, signed_d;
  logic [31:0] hi_d, lo_d;
  logic        busy_d, done_d;
  logic        mt;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] prod;

  MULT32 u_mult_s (
    .a (a_q),
    .b (b_q),
    .p (prod_s)
  );

  MULT32_U u_mult_u (
    .a (a_q),
    .b (b_q),
    .p (prod_u)
  );

  assign prod = signed_q ? prod_s : prod_u;
  assign mt   = MTHI | MTLO;

  // An MT write always lands; in RUN it also cancels the pending commit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    hi_d     = HI;
    lo_d     = LO;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (START && !mt) begin
          state_d  = RUN;
          cnt_d    = CntLoad;
          a_d      = A;
          b_d      = B;
          signed_d = SIGNED;
        end
      end
      RUN: begin
        if (mt) begin
          state_d = IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = IDLE;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (MTHI) hi_d = WDATA;
    if (MTLO) lo_d = WDATA;

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      signed_q <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      HI       <= hi_d;
      LO       <= lo_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
    end
  end

endmodule
